// File: rtl/coin_pkg.sv
// coin_pkg: coin codes and FSM states shared by the coin dispenser and the vending FSM
package coin_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DISPENSE, ST_GAP, ST_FINISH} state_t;
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b10;
    localparam logic [1:0] COIN_10   = 2'b01;
endpackage

// File: rtl/coin_dispenser_if.sv
// coin_dispenser_if: refund request, coin output, completion status and tube stock signals
interface coin_dispenser_if #(
    parameter int AMT_W   = 4,
    parameter int STOCK_W = 4
);
    logic               req_valid;
    logic [AMT_W-1:0]   req_units;
    logic               req_ready;
    logic [1:0]         coins;
    logic               done;
    logic               short;
    logic [AMT_W-1:0]   owed;
    logic               refill5;
    logic               refill10;
    logic [STOCK_W-1:0] stock5;
    logic [STOCK_W-1:0] stock10;
    modport master (
        output req_valid, req_units, refill5, refill10,
        input  req_ready, coins, done, short, owed, stock5, stock10
    );
    modport slave (
        input  req_valid, req_units, refill5, refill10,
        output req_ready, coins, done, short, owed, stock5, stock10
    );
endinterface

// File: rtl/coin_tube.sv
// coin_tube: saturating coin-tube stock counter; simultaneous inc and dec cancel out
module coin_tube #(
    parameter int W    = 4,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= W'(INIT);
        else if (i_inc && !i_dec && r_count != '1)
            r_count <= r_count + 1'b1;
        else if (i_dec && !i_inc && r_count != '0)
            r_count <= r_count - 1'b1;
    end
    assign o_count = r_count;
endmodule

// File: rtl/coin_dispenser.sv
// coin_dispenser: pays a refund as 10c then 5c coin pulses, tracks tube stock and reports shortfall
module coin_dispenser import coin_pkg::*; #(
    parameter int AMT_W        = 4,
    parameter int STOCK_W      = 4,
    parameter int STOCK5_INIT  = 8,
    parameter int STOCK10_INIT = 8,
    parameter int GAP          = 1
) (
    input logic             clk,
    input logic             reset,
    coin_dispenser_if.slave bus
);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t             r_state, w_next;
    logic [AMT_W-1:0]   r_rem, r_owed;
    logic               r_short;
    logic [1:0]         r_coins;
    logic [GAP_W-1:0]   r_gap;
    logic [STOCK_W-1:0] w_stock5, w_stock10;
    logic               w_accept, w_pay10, w_pay5;

    assign w_accept = bus.req_valid && r_state == ST_IDLE;
    // decisions use pre-edge stock; 5c is only used when a 10c would overpay or is unavailable
    assign w_pay10  = r_state == ST_DISPENSE && r_rem >= AMT_W'(2) && w_stock10 != '0;
    assign w_pay5   = r_state == ST_DISPENSE && !w_pay10 && r_rem != '0 && w_stock5 != '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     w_next = !w_accept ? ST_IDLE : (bus.req_units == '0 ? ST_FINISH : ST_DISPENSE);
            ST_DISPENSE: w_next = (w_pay10 || w_pay5) ? ST_GAP : ST_FINISH;
            ST_GAP:      w_next = r_gap != '0 ? ST_GAP : (r_rem == '0 ? ST_FINISH : ST_DISPENSE);
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_owed  <= '0;
            r_short <= 1'b0;
            r_coins <= COIN_NONE;
            r_gap   <= '0;
        end else begin
            r_state <= w_next;
            r_coins <= w_pay10 ? COIN_10 : w_pay5 ? COIN_5 : COIN_NONE;
            r_gap   <= r_state == ST_GAP ? r_gap - 1'b1 : GAP_W'(GAP - 1);
            if (w_accept) begin
                r_rem   <= bus.req_units;
                r_short <= 1'b0;
                r_owed  <= '0;
            end else if (w_pay10) begin
                r_rem <= r_rem - AMT_W'(2);
            end else if (w_pay5) begin
                r_rem <= r_rem - AMT_W'(1);
            end else if (r_state == ST_DISPENSE) begin
                r_short <= 1'b1;
                r_owed  <= r_rem;
            end
        end
    end

    coin_tube #(.W(STOCK_W), .INIT(STOCK5_INIT)) u_tube5 (
        .clk(clk), .reset(reset), .i_inc(bus.refill5), .i_dec(w_pay5), .o_count(w_stock5)
    );
    coin_tube #(.W(STOCK_W), .INIT(STOCK10_INIT)) u_tube10 (
        .clk(clk), .reset(reset), .i_inc(bus.refill10), .i_dec(w_pay10), .o_count(w_stock10)
    );

    assign bus.req_ready = r_state == ST_IDLE;
    assign bus.done      = r_state == ST_FINISH;
    assign bus.coins     = r_coins;
    assign bus.short     = r_short;
    assign bus.owed      = r_owed;
    assign bus.stock5    = w_stock5;
    assign bus.stock10   = w_stock10;
endmodule
